// File: rtl/checker_single.sv
// Single-page signature scan engine for CHECKER_MODE_SINGLE: reads one 4 KiB page as
// 512 quad words. Define CHECKER_SINGLE_COUNT_EN to scan the whole page and count matches.
module checker_single #(
  parameter logic [1:0]  MODE    = 2'd0,
  parameter logic [63:0] PATTERN = 64'h0,
  parameter int          TIMEOUT = 255
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [1:0]  cmode,
  input  logic        cstart,
  input  logic [63:0] caddr,
  output logic        cend,
  output logic [7:0]  cctrl,
  output logic [8:0]  match_offset,
  output logic [9:0]  match_count,
  output logic        mem_stb,
  output logic [63:0] mem_adr,
  input  logic        mem_ack,
  input  logic        mem_err,
  input  logic [63:0] mem_dat_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

`ifdef CHECKER_SINGLE_COUNT_EN
  localparam bit STOP_ON_MATCH = 1'b0;
`else
  localparam bit STOP_ON_MATCH = 1'b1;
`endif

  state_t        state;
  logic          cstart_q;
  logic [51:0]   base;
  logic [8:0]    idx;
  logic [TW-1:0] tcnt;
  logic          start;
  logic          is_match;
  logic          last_word;
  logic          done_now;
  logic          unused_caddr_lo;

  // The page offset bits of caddr carry no meaning for a whole-page scan.
  assign unused_caddr_lo = ^caddr[11:0];

  assign start     = (state == S_IDLE) && cstart && !cstart_q && (cmode == MODE);
  assign is_match  = (mem_dat_i == PATTERN);
  assign last_word = (idx == 9'd511);
  assign mem_adr   = {base, idx, 3'b000};

  // Stop (cstart low) outranks everything, then err, then ack, then timeout expiry.
  always_comb begin
    done_now = 1'b0;
    if (state == S_REQ && cstart) begin
      if (mem_err)      done_now = 1'b1;
      else if (mem_ack) done_now = last_word || (is_match && STOP_ON_MATCH);
      else              done_now = (tcnt == T_LAST);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= S_IDLE;
      cstart_q     <= 1'b0;
      base         <= '0;
      idx          <= '0;
      tcnt         <= '0;
      cend         <= 1'b0;
      cctrl        <= '0;
      match_offset <= '0;
      mem_stb      <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout; the done_now block below deliberately
      // overrides the per-state assignments because the last NBA to a signal wins.
      cstart_q <= cstart;
      cend     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base         <= caddr[63:12];
            idx          <= '0;
            tcnt         <= '0;
            cctrl        <= 8'h01;
            match_offset <= '0;
            mem_stb      <= 1'b1;
            state        <= S_REQ;
          end
        end
        S_REQ: begin
          if (!cstart) begin
            mem_stb <= 1'b0;
            cctrl   <= 8'h10;
            state   <= S_IDLE;
          end else if (mem_err) begin
            cctrl[2] <= 1'b1;
          end else if (mem_ack) begin
            tcnt <= '0;
            // found is still clear exactly when this is the first match of the run.
            if (is_match && !cctrl[1]) match_offset <= idx;
            if (is_match)              cctrl[1]     <= 1'b1;
            if (!done_now)             idx          <= idx + 9'd1;
          end else if (tcnt == T_LAST) begin
            cctrl[3] <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (done_now) begin
        mem_stb  <= 1'b0;
        cctrl[0] <= 1'b0;
        cend     <= 1'b1;
        state    <= S_DONE;
      end
    end
  end

`ifdef CHECKER_SINGLE_COUNT_EN
  logic [9:0] count_q;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      count_q <= '0;
    end else if (start) begin
      count_q <= '0;
    end else if (state == S_REQ && cstart && !mem_err && mem_ack && is_match
                 && count_q != 10'd512) begin
      count_q <= count_q + 10'd1;
    end
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

endmodule

// File: doc/checker_single.md
Name: checker_single

Overview:
- Page-scan engine for CHECKER_MODE_SINGLE. Sits directly downstream of the checker control interface.
- Consumes cmode/cstart/caddr from the control interface. Reads the 4 KiB page at caddr as 512 quad words over a simple 64-bit memory read master, looking for a 64-bit signature.
- Reports completion with a one-cycle cend pulse and a status byte on cctrl.

Parameters:
- MODE, 2'd0, cmode value that selects this engine (CHECKER_MODE_SINGLE).
- PATTERN, 64'h0, 64-bit signature searched for.
- TIMEOUT, 255, maximum cycles mem_stb may stay high without mem_ack before aborting with timeout.

Ports:
- sys_clk  in  1  system clock; the only clock.
- sys_rst_n  in  1  asynchronous reset, active-low.
- cmode  in  2  checker mode from the control interface.
- cstart  in  1  start level from the control interface; deassertion while running means stop.
- caddr  in  64  page address; bits [11:0] are ignored.
- cend  out  1  one-cycle completion pulse.
- cctrl  out  8  status: [0] busy, [1] found, [2] bus error, [3] timeout, [4] aborted, [7:5] zero.
- match_offset  out  9  word index of the first match.
- match_count  out  10  number of matches (optional feature only).
- mem_stb  out  1  read request.
- mem_adr  out  64  read address, 8-byte aligned.
- mem_ack  in  1  read data valid / request done.
- mem_err  in  1  bus error, in place of mem_ack.
- mem_dat_i  in  64  read data.

Behaviour:
- Reset (asynchronous, sys_rst_n low): all outputs 0. State IDLE, word index 0, timeout counter 0, cstart edge register 0.
- Start condition: rising edge of cstart (registered previous value) while cmode==MODE and state IDLE.
  - On start, base is latched as caddr[63:12] and held for the whole run. caddr/cmode changes mid-run are ignored.
  - On start: cctrl cleared to 8'h01 (busy), match_offset and match_count cleared.
  - A cstart level that stays high after completion does not restart the engine. A new rising edge is required.
- States: IDLE, REQ, DONE.
  - IDLE -> REQ on start.
  - REQ:
    - mem_stb=1, mem_adr={base, idx[8:0], 3'b000}. mem_stb rises the cycle after start is sampled.
    - mem_stb stays high and mem_adr stable until mem_ack or mem_err.
    - On mem_ack with mem_dat_i==PATTERN: found=1, match_offset=idx, go DONE.
    - On mem_ack with no match: idx==511 -> DONE (found=0); otherwise idx+1 and mem_stb stays high for the next word, giving back-to-back reads.
    - On mem_err: cctrl[2]=1, go DONE.
    - When the timeout counter reaches TIMEOUT without ack/err: cctrl[3]=1, go DONE. The counter resets on every ack.
  - DONE: mem_stb=0, cend=1 for exactly one cycle, busy cleared, next state IDLE.
- Completion latency: last accepted ack at cycle N -> cend high at N+1. Result bits in cctrl are valid from N+1 and hold until the next start.
- Stop: cstart low while in REQ.
  - mem_stb drops the next cycle; any ack in that cycle is ignored.
  - cctrl = 8'h10 (aborted). No cend pulse. Return to IDLE.
- Simultaneous events:
  - mem_err and mem_ack in the same cycle: err wins.
  - Ack and timeout expiry in the same cycle: ack wins.
  - Stop and ack in the same cycle: stop wins, and the data is discarded.
- mem_ack/mem_err while mem_stb is low are ignored.
- Word index is 9 bits; it never wraps inside a run because the run ends at 511.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. No cend.

Optional Feature:
- Macro CHECKER_SINGLE_COUNT_EN.
- Defined:
  - A match does not terminate the run; the whole page is always scanned.
  - match_count increments per match (saturates at 512, so no wrap).
  - match_offset holds the first match; found = (match_count != 0).
  - cend follows the ack of word 511.
- Undefined:
  - Stop on first match.
  - match_count tied to 0; its counter logic is not synthesized.

Test Plan:
- cmode=MODE, caddr=64'h1234_5678_9ABC_DFFF, cstart rise, PATTERN at word 7 -> mem_adr sequence 64'h1234_5678_9ABC_D000, ..._D008, ... up to ..._D038; cend one cycle after the 8th ack; cctrl=8'h02; match_offset=7.
- No match, ack every cycle -> 512 reads; cend one cycle after the ack at ..._DFF8; cctrl=8'h00; cstart held high afterwards causes no second run.
- mem_err on word 3 -> cend pulse; cctrl=8'h04; mem_stb low in the cend cycle.
- No ack for TIMEOUT=255 cycles on word 0 -> cctrl=8'h08; cend pulse. Separately, ack and timeout in the same cycle -> treated as ack.
- cstart falls during word 100 -> mem_stb low the next cycle; cctrl=8'h10; no cend. Separately, cmode!=MODE with a cstart rise -> mem_stb stays 0.
- With CHECKER_SINGLE_COUNT_EN, PATTERN at words 0, 5 and 511 -> full 512-word scan; match_count=3; match_offset=0; cctrl=8'h02. Separately, sys_rst_n pulsed mid-run -> all outputs 0 immediately.
